// File: rtl/code_decimator.sv
// Boxcar decimator: averages 2^LOG2_N valid codes into one; CODE_DECIM_ROUND_EN selects round-half-up over truncation.
// Latency: result visible on avg_o/avg_valid_o one cycle after the last sample of a block (FIFO empty).
// Backpressure: 2-entry output FIFO on valid/ready; upstream never stalls, results arriving to a full FIFO are dropped and flag overrun_o.
module code_decimator #(
    parameter int DATA_W = 6,
    parameter int LOG2_N = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [DATA_W-1:0]                    din_i,
    input  logic                                 din_valid_i,
    input  logic                                 clear_i,
    output logic [DATA_W-1:0]                    avg_o,
    output logic                                 avg_valid_o,
    input  logic                                 avg_ready_i,
    output logic                                 overrun_o,
    output logic [((LOG2_N > 0) ? LOG2_N : 1)-1:0] sample_cnt_o
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int ACC_W = DATA_W + LOG2_N;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              vld_q, vld_d;
    logic              ovr_q, ovr_d;

    logic [ACC_W-1:0]  sum_w;
    logic [DATA_W-1:0] res_w;
    logic              last_w;
    logic              push_w;
    logic              pop_w;

    assign sum_w  = acc_q + ACC_W'(din_i);
    assign last_w = (LOG2_N == 0) || (cnt_q == CNT_W'(N - 1));

`ifdef CODE_DECIM_ROUND_EN
    // N*(2^DATA_W-1) + N/2 still fits in ACC_W bits, so no carry out.
    assign res_w = DATA_W'((sum_w + ACC_W'(N / 2)) >> LOG2_N);
`else
    assign res_w = DATA_W'(sum_w >> LOG2_N);
`endif

    assign push_w = din_valid_i && last_w && !clear_i;
    assign pop_w  = vld_q && avg_ready_i;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (din_valid_i) begin
            if (last_w) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ovr_d   = ovr_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_w) begin
                        head_d  = res_w;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push_w && pop_w) begin
                        head_d = res_w;
                    end else if (push_w) begin
                        tail_d  = res_w;
                        state_d = ST_FULL;
                    end else if (pop_w) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_w) begin
                        head_d = tail_q;
                        if (push_w) begin
                            tail_d = res_w;
                        end else begin
                            state_d = ST_ONE;
                        end
                    end else if (push_w) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        vld_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign avg_o        = head_q;
    assign avg_valid_o  = vld_q;
    assign overrun_o    = ovr_q;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_code_decimator.sv
// Directed bench for code_decimator (DATA_W=6, LOG2_N=2) with hand-computed expectations.
module tb_code_decimator;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [5:0] din_i;
    logic       din_valid_i;
    logic       clear_i;
    logic [5:0] avg_o;
    logic       avg_valid_o;
    logic       avg_ready_i;
    logic       overrun_o;
    logic [1:0] sample_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    code_decimator #(.DATA_W(6), .LOG2_N(2)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .din_i        (din_i),
        .din_valid_i  (din_valid_i),
        .clear_i      (clear_i),
        .avg_o        (avg_o),
        .avg_valid_o  (avg_valid_o),
        .avg_ready_i  (avg_ready_i),
        .overrun_o    (overrun_o),
        .sample_cnt_o (sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given sample; outputs are sampled 1ns after the edge.
    task automatic step(input logic vld, input logic [5:0] d);
        din_i       = d;
        din_valid_i = vld;
        @(posedge clk_i);
        #1;
        din_valid_i = 1'b0;
    endtask

    task automatic block4(input logic [5:0] d);
        for (int i = 0; i < 4; i++) step(1'b1, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i     = 1'b0;
        din_i       = '0;
        din_valid_i = 1'b0;
        clear_i     = 1'b0;
        avg_ready_i = 1'b1;
        #12;
        chk("rst_vld", avg_valid_o, 0);
        chk("rst_avg", avg_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_cnt", sample_cnt_o, 0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic average 10..13
        step(1'b1, 6'd10);
        step(1'b1, 6'd11);
        step(1'b1, 6'd12);
        chk("basic_cnt3", sample_cnt_o, 3);
        chk("basic_vld_pre", avg_valid_o, 0);
        step(1'b1, 6'd13);
        chk("basic_vld", avg_valid_o, 1);
`ifdef CODE_DECIM_ROUND_EN
        chk("basic_avg", avg_o, 12);
`else
        chk("basic_avg", avg_o, 11);
`endif
        chk("basic_cnt0", sample_cnt_o, 0);
        step(1'b0, 6'd0);
        chk("basic_vld_1cyc", avg_valid_o, 0);

        // Full scale with gaps
        chk("gap_cnt_0", sample_cnt_o, 0);
        step(1'b1, 6'd63); chk("gap_cnt_1", sample_cnt_o, 1);
        step(1'b0, 6'd0);  chk("gap_cnt_2", sample_cnt_o, 1);
        step(1'b1, 6'd63); chk("gap_cnt_3", sample_cnt_o, 2);
        step(1'b0, 6'd0);  chk("gap_cnt_4", sample_cnt_o, 2);
        step(1'b1, 6'd63); chk("gap_cnt_5", sample_cnt_o, 3);
        step(1'b0, 6'd0);  chk("gap_cnt_6", sample_cnt_o, 3);
        chk("gap_vld_pre", avg_valid_o, 0);
        step(1'b1, 6'd63); chk("gap_cnt_7", sample_cnt_o, 0);
        chk("gap_vld", avg_valid_o, 1);
        chk("gap_avg", avg_o, 63);
        step(1'b0, 6'd0);
        chk("gap_popped", avg_valid_o, 0);
        chk("gap_avg_hold", avg_o, 63);

        // Backpressure and overrun
        avg_ready_i = 1'b0;
        block4(6'd5);
        chk("bp_vld1", avg_valid_o, 1);
        chk("bp_head1", avg_o, 5);
        block4(6'd6);
        chk("bp_head2", avg_o, 5);
        chk("bp_ovr_pre", overrun_o, 0);
        block4(6'd7);
        chk("bp_ovr", overrun_o, 1);
        chk("bp_head3", avg_o, 5);
        avg_ready_i = 1'b1;
        step(1'b0, 6'd0);
        chk("bp_out2", avg_o, 6);
        chk("bp_vld2", avg_valid_o, 1);
        step(1'b0, 6'd0);
        chk("bp_drain", avg_valid_o, 0);
        chk("bp_ovr_sticky", overrun_o, 1);

        // clear mid-block, discarding the sample presented with it
        step(1'b1, 6'd30);
        step(1'b1, 6'd30);
        chk("clr_cnt_pre", sample_cnt_o, 2);
        clear_i = 1'b1;
        step(1'b1, 6'd40);
        clear_i = 1'b0;
        chk("clr_cnt", sample_cnt_o, 0);
        chk("clr_ovr", overrun_o, 0);
        chk("clr_vld", avg_valid_o, 0);
        step(1'b1, 6'd8);
        step(1'b1, 6'd8);
        step(1'b1, 6'd8);
        chk("clr_vld_early", avg_valid_o, 0);
        step(1'b1, 6'd8);
        chk("clr_vld_post", avg_valid_o, 1);
        chk("clr_avg", avg_o, 8);
        step(1'b0, 6'd0);

        // Full FIFO with simultaneous push and pop
        avg_ready_i = 1'b0;
        block4(6'd5);
        block4(6'd6);
        step(1'b1, 6'd7);
        step(1'b1, 6'd7);
        step(1'b1, 6'd7);
        avg_ready_i = 1'b1;
        step(1'b1, 6'd7);
        avg_ready_i = 1'b0;
        chk("pp_head", avg_o, 6);
        chk("pp_vld", avg_valid_o, 1);
        chk("pp_ovr", overrun_o, 0);
        avg_ready_i = 1'b1;
        step(1'b0, 6'd0);
        chk("pp_tail", avg_o, 7);
        chk("pp_tail_vld", avg_valid_o, 1);
        step(1'b0, 6'd0);
        chk("pp_drain", avg_valid_o, 0);

        // Async reset with FIFO full and a partial block
        avg_ready_i = 1'b0;
        block4(6'd5);
        block4(6'd6);
        step(1'b1, 6'd9);
        step(1'b1, 6'd9);
        chk("ar_cnt_pre", sample_cnt_o, 2);
        chk("ar_vld_pre", avg_valid_o, 1);
        reset_i = 1'b0;
        #1;
        chk("ar_vld", avg_valid_o, 0);
        chk("ar_avg", avg_o, 0);
        chk("ar_cnt", sample_cnt_o, 0);
        @(posedge clk_i);
        #2;
        reset_i     = 1'b1;
        avg_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("ar_vld_idle", avg_valid_o, 0);
        block4(6'd20);
        chk("ar_post_vld", avg_valid_o, 1);
        chk("ar_post_avg", avg_o, 20);
        step(1'b0, 6'd0);
        chk("ar_post_drain", avg_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/code_decimator.md
Name: code_decimator

Overview:
- Consumes the 6-bit aligned code {MSBs, LSBs} from the two-stage time-alignment stage. It sits directly downstream of that stage.
- Averages each non-overlapping block of 2^LOG2_N valid codes into one output code (boxcar decimation).
- Results are buffered in a 2-entry output FIFO with a valid/ready handshake toward the next consumer.
- Upstream has no backpressure. If the FIFO is full when a result is produced, the result is dropped and a sticky overrun flag is raised.

Parameters:
- DATA_W, 6, width of input and output code.
- LOG2_N, 2, log2 of the decimation ratio N. Legal range 0..4; N=4 by default.

Ports:
- clk_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- din_i  in  DATA_W  aligned code from the time-alignment stage.
- din_valid_i  in  1  din_i is a valid sample this cycle.
- clear_i  in  1  synchronous restart: clears accumulator, counter, FIFO and overrun.
- avg_o  out  DATA_W  decimated code at the FIFO head.
- avg_valid_o  out  1  avg_o is valid.
- avg_ready_i  in  1  consumer accepts avg_o; a transfer happens when valid and ready are both 1.
- overrun_o  out  1  sticky flag: at least one result was dropped.
- sample_cnt_o  out  max(LOG2_N,1)  samples accumulated in the current block.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - acc=0, cnt=0, FIFO empty.
  - avg_o=0, avg_valid_o=0, overrun_o=0, sample_cnt_o=0.
  - Reset asserted mid-block discards the partial block and all buffered results. Outputs go to reset values immediately.
- Accumulator:
  - Width DATA_W+LOG2_N, unsigned; cannot overflow.
  - Each cycle with din_valid_i=1: acc += din_i and cnt += 1.
- Block completion:
  - When din_valid_i=1 and cnt==N-1, the result is (acc+din_i) >> LOG2_N, truncated.
  - That result is pushed to the FIFO in the same cycle, and acc/cnt return to 0 in the same cycle.
  - Latency: avg_valid_o rises the cycle after the Nth sample is accepted, provided the FIFO was empty.
- Inputs are always accepted. Gaps in din_valid_i only stall accumulation.
- LOG2_N=0: every valid sample is pushed unmodified, with 1-cycle latency.
- FIFO occupancy FSM, 2 entries, first-in first-out:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop -> ONE.
  - FULL: pop -> ONE; push and pop -> FULL, no loss; push without pop -> FULL, result dropped, overrun_o=1 from the next cycle.
  - avg_o always shows the head entry. It is held stable while avg_valid_o=1 and avg_ready_i=0.
  - avg_valid_o=1 in states ONE and FULL.
  - avg_o holds its last value when the FIFO is EMPTY (0 after reset).
- overrun_o is sticky until clear_i or reset.
- clear_i (synchronous, highest priority):
  - Next state: acc=0, cnt=0, FIFO EMPTY, overrun_o=0.
  - A sample presented in the same cycle is discarded.
  - A pop in the same cycle still completes from the consumer's view; the entry is flushed either way.

Optional Feature:
- Macro: CODE_DECIM_ROUND_EN.
- Defined: result is (acc+din_i+2^(LOG2_N-1)) >> LOG2_N, i.e. round-half-up. The maximum stays 2^DATA_W-1, so no saturation logic is needed. For LOG2_N=0 the result is identical to the undefined case.
- Undefined: truncation as specified above; no rounding adder is built.

Test Plan:
- Basic average (N=4, avg_ready_i=1): samples 10,11,12,13 on consecutive cycles -> one cycle after 13, avg_valid_o=1 for 1 cycle and avg_o=11. With CODE_DECIM_ROUND_EN, avg_o=12.
- Full scale with gaps: four samples of 63 with din_valid_i=0 on alternate cycles -> avg_o=63, sample_cnt_o sequence 0,1,1,2,2,3,3,0.
- Backpressure and overrun: avg_ready_i=0, blocks averaging 5, 6, 7 -> FIFO holds 5 at head then 6; 7 is dropped and overrun_o=1. Raising avg_ready_i then yields 5, 6, then avg_valid_o=0.
- Full with simultaneous push/pop: FIFO full (5,6), avg_ready_i=1 in the cycle block 7 completes -> 5 popped, FIFO holds 6,7, overrun_o stays 0.
- clear_i mid-block: 2 samples accepted, then clear_i pulsed with a sample of 40 in the same cycle -> sample_cnt_o=0, overrun_o=0. The next 4 samples of 8 yield avg_o=8.
- Reset mid-operation: reset_i low for 1 cycle with FIFO FULL and cnt=2 -> avg_valid_o=0, avg_o=0, sample_cnt_o=0 immediately. After release, 4 samples of 20 yield avg_o=20.
